ram_cmd_seq: RTL and testbench

- Command sequencer that sits directly upstream of dev_ram and drives its op, data_type, addr and data_in fields.
- Accepts byte-level commands over a valid/ready handshake: set address, write byte, and read byte.
- Turns each command into single-cycle RAM_STORE or RAM_FETCH pulses and auto-increments the address.
- Returns fetched bytes on a valid/ready response channel. Replaces the ad-hoc button decoding in board top levels.

---
 rtl/ram_cmd_seq.sv | 178 +++++++++++++++++
 tb/tb_ram_cmd_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_seq.sv
// ram_cmd_seq: byte-command sequencer driving a dev_ram port.
//
// pkg_ram carries the RAM op/type encodings shared with dev_ram.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cmd_valid/ready  command handshake; cmd_code 00=SET_ADDR 01=WRITE
//                    10=READ 11=NOP, cmd_data = address or data byte
//   rsp_valid/ready  read response handshake; rsp_data = fetched byte,
//                    rsp_hi_zero = upper fetched bits were all zero
//   ram_op, ram_data_type, ram_addr, ram_data_in  registered RAM controls
//   ram_data_out     RAM read data
//   busy             sequencer is not idle
package pkg_ram;
  localparam int unsigned RAM_ADDRW     = 8;
  localparam int unsigned RAM_LONG_SIZE = 32;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_STORE = 2'd1,
    RAM_FETCH = 2'd2
  } ram_op_e;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_HALF = 2'd1,
    RAM_LONG = 2'd2
  } ram_type_e;
endpackage

module ram_cmd_seq #(
  parameter int unsigned ADDRW     = 8,
  parameter int unsigned DATAW     = 32,
  parameter int unsigned FETCH_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_code,
  input  logic [7:0]          cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [7:0]          rsp_data,
  output logic                rsp_hi_zero,
  output pkg_ram::ram_op_e    ram_op,
  output pkg_ram::ram_type_e  ram_data_type,
  output logic [ADDRW-1:0]    ram_addr,
  output logic [DATAW-1:0]    ram_data_in,
  input  logic [DATAW-1:0]    ram_data_out,
  output logic                busy
);
  import pkg_ram::*;

  localparam int unsigned CNTW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FETCH_LAT - 1);

  localparam logic [1:0] C_SET = 2'b00;
  localparam logic [1:0] C_WR  = 2'b01;
  localparam logic [1:0] C_RD  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_FETCH, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  ram_op_e          op_q, op_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] din_q, din_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_hz_q, rsp_hz_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             accept;
  logic             capture;

  assign accept  = cmd_valid && (state_q == S_IDLE);
  // The FETCH op is registered, so data is valid FETCH_LAT cycles after
  // the FETCH cycle; WAIT spans exactly those FETCH_LAT cycles.
  assign capture = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_code == C_WR)      state_d = S_STORE;
          else if (cmd_code == C_RD) state_d = S_FETCH;
        end
      end
      S_STORE: state_d = S_IDLE;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  if (capture)   state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
  end

  // Datapath next values
  always_comb begin
    op_d        = RAM_NOP;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_hz_d    = rsp_hz_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_code == C_SET) begin
            addr_d = ADDRW'(cmd_data);
          end else if (cmd_code == C_WR) begin
            din_d = DATAW'(cmd_data);
            op_d  = RAM_STORE;
          end else if (cmd_code == C_RD) begin
            op_d = RAM_FETCH;
          end
        end
      end
      S_STORE: addr_d = addr_q + 1'b1;
      S_FETCH: cnt_d = '0;
      S_WAIT: begin
        if (capture) begin
          rsp_data_d  = ram_data_out[7:0];
          rsp_hz_d    = (ram_data_out[DATAW-1:8] == '0);
          rsp_valid_d = 1'b1;
          addr_d      = addr_q + 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= RAM_NOP;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hz_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hz_q    <= rsp_hz_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ram_op        = op_q;
  assign ram_data_type = RAM_BYTE;
  assign ram_addr      = addr_q;
  assign ram_data_in   = din_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_hi_zero   = rsp_hz_q;

endmodule

// File: tb/tb_ram_cmd_seq.sv
// Testbench for ram_cmd_seq: instance A (FETCH_LAT=1) with a behavioural
// byte RAM, instance B (FETCH_LAT=3) with a fixed-value delayed read model.
module tb_ram_cmd_seq;
  import pkg_ram::*;

  localparam logic [1:0] C_SET = 2'b00;
  localparam logic [1:0] C_WR  = 2'b01;
  localparam logic [1:0] C_RD  = 2'b10;
  localparam logic [1:0] C_NOP = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT A signals
  logic       a_cmd_valid = 1'b0, a_cmd_ready, a_rsp_valid, a_rsp_ready = 1'b0;
  logic       a_rsp_hz, a_busy;
  logic [1:0] a_code = 2'b11;
  logic [7:0] a_cmd_data = 8'h00, a_rsp_data, a_addr;
  ram_op_e    a_op;
  ram_type_e  a_type;
  logic [31:0] a_din, a_dout;

  // DUT B signals
  logic       b_cmd_valid = 1'b0, b_cmd_ready, b_rsp_valid, b_rsp_ready = 1'b0;
  logic       b_rsp_hz, b_busy;
  logic [1:0] b_code = 2'b11;
  logic [7:0] b_cmd_data = 8'h00, b_rsp_data, b_addr;
  ram_op_e    b_op;
  ram_type_e  b_type;
  logic [31:0] b_din, b_dout;

  ram_cmd_seq #(.ADDRW(8), .DATAW(32), .FETCH_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_code(a_code), .cmd_data(a_cmd_data), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_hi_zero(a_rsp_hz),
    .ram_op(a_op), .ram_data_type(a_type), .ram_addr(a_addr),
    .ram_data_in(a_din), .ram_data_out(a_dout), .busy(a_busy));

  ram_cmd_seq #(.ADDRW(8), .DATAW(32), .FETCH_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_code(b_code), .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_hi_zero(b_rsp_hz),
    .ram_op(b_op), .ram_data_type(b_type), .ram_addr(b_addr),
    .ram_data_in(b_din), .ram_data_out(b_dout), .busy(b_busy));

  // Byte RAM for A: one-cycle registered read
  logic [31:0] mem [256];
  logic [31:0] a_rd = 32'h0;
  always @(posedge clk) begin
    if (a_op == RAM_STORE)      mem[a_addr] <= {24'h0, a_din[7:0]};
    else if (a_op == RAM_FETCH) a_rd <= mem[a_addr];
  end
  assign a_dout = a_rd;

  // Model for B: 0x00012345 exactly three cycles after a FETCH, junk otherwise
  logic [31:0] b_p0 = 32'hDEADBEEF, b_p1 = 32'hDEADBEEF, b_p2 = 32'hDEADBEEF;
  always @(posedge clk) begin
    b_p0 <= (b_op == RAM_FETCH) ? 32'h0001_2345 : 32'hDEAD_BEEF;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_dout = b_p2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [1:0] code, input logic [7:0] d, input string nm);
    int n = 0;
    a_cmd_valid = 1'b1;
    a_code      = code;
    a_cmd_data  = d;
    while (!a_cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk({nm, " ready"}, 32'(a_cmd_ready), 32'd1);
    step();
    a_cmd_valid = 1'b0;
    a_code      = C_NOP;
  endtask

  typedef struct {
    logic [1:0] code;
    logic [7:0] data;
    logic [7:0] op_addr;
    logic [7:0] rdata;
    logic       hz;
    logic [7:0] end_addr;
  } vec_t;

  vec_t vecs [14];

  task automatic run_vec(input int i, input vec_t v);
    int n;
    string p;
    p = $sformatf("v%0d", i);
    a_send(v.code, v.data, p);
    case (v.code)
      C_WR: begin
        chk({p, " op"}, 32'(a_op), 32'(RAM_STORE));
        chk({p, " addr"}, 32'(a_addr), 32'(v.op_addr));
        chk({p, " din"}, a_din, {24'h0, v.data});
        chk({p, " rdy"}, 32'(a_cmd_ready), 32'd0);
        step();
        chk({p, " op2"}, 32'(a_op), 32'(RAM_NOP));
        chk({p, " addr2"}, 32'(a_addr), 32'(v.end_addr));
        chk({p, " rdy2"}, 32'(a_cmd_ready), 32'd1);
      end
      C_RD: begin
        chk({p, " op"}, 32'(a_op), 32'(RAM_FETCH));
        chk({p, " addr"}, 32'(a_addr), 32'(v.op_addr));
        chk({p, " rv0"}, 32'(a_rsp_valid), 32'd0);
        n = 0;
        do begin
          step();
          n++;
        end while (!a_rsp_valid && n < 20);
        chk({p, " lat"}, 32'(n), 32'd2);
        chk({p, " rdata"}, 32'(a_rsp_data), 32'(v.rdata));
        chk({p, " hz"}, 32'(a_rsp_hz), 32'(v.hz));
        chk({p, " addr2"}, 32'(a_addr), 32'(v.end_addr));
        chk({p, " rdy"}, 32'(a_cmd_ready), 32'd0);
        a_rsp_ready = 1'b1;
        step();
        a_rsp_ready = 1'b0;
        chk({p, " rv1"}, 32'(a_rsp_valid), 32'd0);
        chk({p, " rdy2"}, 32'(a_cmd_ready), 32'd1);
      end
      default: begin
        chk({p, " op"}, 32'(a_op), 32'(RAM_NOP));
        chk({p, " addr"}, 32'(a_addr), 32'(v.end_addr));
        chk({p, " rdy"}, 32'(a_cmd_ready), 32'd1);
      end
    endcase
  endtask

  initial begin
    int n;
    //          code   data   op_addr rdata  hz    end_addr
    vecs[0]  = '{C_SET, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{C_WR,  8'h77, 8'h00, 8'h00, 1'b0, 8'h01};
    vecs[2]  = '{C_SET, 8'h10, 8'h00, 8'h00, 1'b0, 8'h10};
    vecs[3]  = '{C_WR,  8'hA5, 8'h10, 8'h00, 1'b0, 8'h11};
    vecs[4]  = '{C_WR,  8'h3C, 8'h11, 8'h00, 1'b0, 8'h12};
    vecs[5]  = '{C_SET, 8'h10, 8'h00, 8'h00, 1'b0, 8'h10};
    vecs[6]  = '{C_RD,  8'h00, 8'h10, 8'hA5, 1'b1, 8'h11};
    vecs[7]  = '{C_RD,  8'h00, 8'h11, 8'h3C, 1'b1, 8'h12};
    vecs[8]  = '{C_NOP, 8'h55, 8'h00, 8'h00, 1'b0, 8'h12};
    vecs[9]  = '{C_SET, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hFF};
    vecs[10] = '{C_WR,  8'h01, 8'hFF, 8'h00, 1'b0, 8'h00};
    vecs[11] = '{C_RD,  8'h00, 8'h00, 8'h77, 1'b1, 8'h01};
    vecs[12] = '{C_SET, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hFF};
    vecs[13] = '{C_RD,  8'h00, 8'hFF, 8'h01, 1'b1, 8'h00};

    // Reset state
    step();
    step();
    chk("rst a op", 32'(a_op), 32'(RAM_NOP));
    chk("rst a addr", 32'(a_addr), 32'h0);
    chk("rst a din", a_din, 32'h0);
    chk("rst a rv", 32'(a_rsp_valid), 32'd0);
    chk("rst a rdata", 32'(a_rsp_data), 32'h0);
    chk("rst a hz", 32'(a_rsp_hz), 32'd0);
    chk("rst a type", 32'(a_type), 32'(RAM_BYTE));
    chk("rst a rdy", 32'(a_cmd_ready), 32'd1);
    chk("rst a busy", 32'(a_busy), 32'd0);
    chk("rst b op", 32'(b_op), 32'(RAM_NOP));
    chk("rst b rv", 32'(b_rsp_valid), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Back-to-back SET_ADDR every cycle
    a_cmd_valid = 1'b1;
    a_code      = C_SET;
    for (int i = 0; i < 3; i++) begin
      a_cmd_data = 8'h20 + 8'(i);
      step();
      chk($sformatf("b2b addr%0d", i), 32'(a_addr), 32'h20 + 32'(i));
      chk($sformatf("b2b rdy%0d", i), 32'(a_cmd_ready), 32'd1);
      chk($sformatf("b2b op%0d", i), 32'(a_op), 32'(RAM_NOP));
    end
    a_cmd_valid = 1'b0;

    // Response held with rsp_ready low; a WRITE held on the command port
    a_send(C_SET, 8'h10, "hold set");
    a_send(C_RD, 8'h00, "hold rd");
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      step();
      n++;
    end
    a_cmd_valid = 1'b1;
    a_code      = C_WR;
    a_cmd_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold rv%0d", i), 32'(a_rsp_valid), 32'd1);
      chk($sformatf("hold rdata%0d", i), 32'(a_rsp_data), 32'hA5);
      chk($sformatf("hold hz%0d", i), 32'(a_rsp_hz), 32'd1);
      chk($sformatf("hold rdy%0d", i), 32'(a_cmd_ready), 32'd0);
      chk($sformatf("hold op%0d", i), 32'(a_op), 32'(RAM_NOP));
      chk($sformatf("hold din%0d", i), a_din, 32'h01);
      step();
    end
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    chk("hold rv off", 32'(a_rsp_valid), 32'd0);
    chk("hold idle rdy", 32'(a_cmd_ready), 32'd1);
    chk("hold no accept", 32'(a_op), 32'(RAM_NOP));
    chk("hold addr", 32'(a_addr), 32'h11);
    step();
    a_cmd_valid = 1'b0;
    chk("late wr op", 32'(a_op), 32'(RAM_STORE));
    chk("late wr addr", 32'(a_addr), 32'h11);
    chk("late wr din", a_din, 32'hEE);
    step();
    chk("late wr addr2", 32'(a_addr), 32'h12);

    // Reset asserted during the FETCH cycle
    a_send(C_SET, 8'h40, "rst set");
    a_send(C_RD, 8'h00, "rst rd");
    chk("rst mid op", 32'(a_op), 32'(RAM_FETCH));
    rst_n = 1'b0;
    #1;
    chk("rst mid op0", 32'(a_op), 32'(RAM_NOP));
    chk("rst mid rv", 32'(a_rsp_valid), 32'd0);
    chk("rst mid addr", 32'(a_addr), 32'h0);
    chk("rst mid busy", 32'(a_busy), 32'd0);
    chk("rst mid type", 32'(a_type), 32'(RAM_BYTE));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("post rst rdy", 32'(a_cmd_ready), 32'd1);
    chk("post rst rv", 32'(a_rsp_valid), 32'd0);
    chk("post rst op", 32'(a_op), 32'(RAM_NOP));
    chk("post rst addr", 32'(a_addr), 32'h0);

    // FETCH_LAT=3 instance
    b_cmd_valid = 1'b1;
    b_code      = C_RD;
    chk("b rdy", 32'(b_cmd_ready), 32'd1);
    step();
    b_cmd_valid = 1'b0;
    b_code      = C_NOP;
    chk("b op", 32'(b_op), 32'(RAM_FETCH));
    chk("b addr", 32'(b_addr), 32'h0);
    n = 0;
    do begin
      step();
      n++;
    end while (!b_rsp_valid && n < 20);
    chk("b lat", 32'(n), 32'd4);
    chk("b rdata", 32'(b_rsp_data), 32'h45);
    chk("b hz", 32'(b_rsp_hz), 32'd0);
    chk("b addr2", 32'(b_addr), 32'h1);
    chk("b busy", 32'(b_busy), 32'd1);
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
    chk("b rv off", 32'(b_rsp_valid), 32'd0);
    chk("b idle", 32'(b_cmd_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish, limit 200000");
    $fatal(1, "timeout");
  end

endmodule
